// File: rtl/tick_monitor.sv
// Tick-interval monitor: measures the spacing of single-cycle ticks, declares lock, flags timeouts.
// Optional error counter built only when TICK_MONITOR_ERRCNT_EN is defined.
module tick_monitor #(
    parameter int EXPECTED   = 25,
    parameter int TOLERANCE  = 1,
    parameter int LOCK_COUNT = 4,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             missing,
    output logic [7:0]       err_count
);

    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] LO      = WIDTH'(EXPECTED - TOLERANCE);
    localparam logic [WIDTH-1:0] HI      = WIDTH'(EXPECTED + TOLERANCE);
    localparam logic [GW-1:0]    GOAL_M1 = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [GW-1:0]    r_good, w_good_nxt;
    logic [WIDTH-1:0] r_period;
    logic             r_period_valid, r_locked, r_missing;
    logic             w_good_ivl, w_timeout, w_report, w_err, w_miss;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_good_nxt  = r_good;
        w_report    = 1'b0;
        w_err       = 1'b0;
        w_miss      = 1'b0;
        w_good_ivl  = (r_cnt >= LO) && (r_cnt <= HI);
        w_timeout   = (r_state != S_IDLE) && !pulse && (r_cnt == HI);

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (pulse) begin
                    w_state_nxt = S_ACQUIRE;
                    w_cnt_nxt   = WIDTH'(1);
                    w_good_nxt  = '0;
                end
            end
            S_ACQUIRE, S_LOCKED: begin
                w_cnt_nxt = pulse ? WIDTH'(1) : r_cnt + WIDTH'(1);
                if (pulse) begin
                    w_report = 1'b1;
                    if (w_good_ivl) begin
                        // In LOCKED the run counter is already at its goal and simply holds.
                        if (r_state == S_ACQUIRE) begin
                            w_good_nxt = r_good + GW'(1);
                            if (r_good == GOAL_M1)
                                w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_err       = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = S_ACQUIRE;
                    end
                end else if (w_timeout) begin
                    w_miss      = 1'b1;
                    w_err       = 1'b1;
                    w_good_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_good         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_missing      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_good         <= w_good_nxt;
            r_period_valid <= w_report;
            r_missing      <= w_miss;
            r_locked       <= (w_state_nxt == S_LOCKED);
            if (w_report)
                r_period <= r_cnt;
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign missing      = r_missing;

`ifdef TICK_MONITOR_ERRCNT_EN
    logic [7:0] r_err_count;

    // clear wins over a same-cycle error
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err_count <= 8'd0;
        else if (clear)
            r_err_count <= 8'd0;
        else if (w_err && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
    end

    assign err_count = r_err_count;
`else
    logic [1:0] w_unused;
    assign w_unused  = {clear, w_err};
    assign err_count = 8'd0;
`endif

endmodule
